// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: per-bit toggle, up/down counter, or parallel load.
// Optional registered parity output is enabled by defining TFF_BANK_PARITY_EN.
module tff_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             tc,
   output logic [WIDTH-1:0] toggled
`ifdef TFF_BANK_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_LOAD   = 2'b11;

   logic [WIDTH-1:0] q_reg, q_bar_reg, toggled_reg;
   logic [WIDTH-1:0] q_next, up_t, dn_t;
   logic             tc_reg, tc_next;

   // Ripple T chains: a bit toggles when every lower bit is 1 (up) or 0 (down).
   assign up_t[0] = 1'b1;
   assign dn_t[0] = 1'b1;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign up_t[gi] = up_t[gi-1] &  q_reg[gi-1];
         assign dn_t[gi] = dn_t[gi-1] & ~q_reg[gi-1];
      end
   endgenerate

   always_comb begin
      q_next  = q_reg;
      tc_next = 1'b0;
      if (en) begin
         case (mode)
            MODE_TOGGLE: q_next = q_reg ^ t;
            MODE_UP: begin
               q_next  = q_reg ^ up_t;
               tc_next = &q_reg;
            end
            MODE_DOWN: begin
               q_next  = q_reg ^ dn_t;
               tc_next = ~|q_reg;
            end
            MODE_LOAD: q_next = d;
            default:   q_next = q_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg       <= RST_VAL;
         q_bar_reg   <= ~RST_VAL;
         tc_reg      <= 1'b0;
         toggled_reg <= {WIDTH{1'b0}};
      end else begin
         q_reg       <= q_next;
         q_bar_reg   <= ~q_next;
         tc_reg      <= tc_next;
         toggled_reg <= q_reg ^ q_next;
      end
   end

   assign q       = q_reg;
   assign q_bar   = q_bar_reg;
   assign tc      = tc_reg;
   assign toggled = toggled_reg;

`ifdef TFF_BANK_PARITY_EN
   logic parity_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_reg <= ^RST_VAL;
      else     parity_reg <= ^q_next;
   end

   assign parity = parity_reg;
`endif

endmodule
